abc_vector_sequencer: RTL and testbench

Upstream stimulus stage for the `parallelblock` AND-pair datapath. It steps through the 3-bit `{a,b,c}` input space, one vector at a time. Each vector is held stable for a programmable settle time, then offered with a valid/ready handshake. Registered expected results (`a&b`, `a&c`) travel alongside each vector so a downstream checker can compare against `out1`/`out2` without recomputing them.

---
 rtl/abc_vector_sequencer.sv | 140 ++++++++++++++
 tb/tb_abc_vector_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/abc_vector_sequencer.sv
// abc_vector_sequencer
// Steps through the 3-bit {a,b,c} input space for the parallelblock AND-pair
// datapath. Each vector is held for HOLD_CYCLES cycles and then offered with
// a valid/ready handshake. Registered expected results (a&b, a&c) travel
// with every vector so a downstream checker need not recompute them.
//
// Build option: define ABC_SEQ_GRAY_EN to drive the vectors in Gray order
// (vec_idx ^ (vec_idx >> 1)) instead of plain binary order. Handshake and
// timing are the same in both builds.
module abc_vector_sequencer #(
    parameter int HOLD_CYCLES = 5,
    parameter int NUM_VEC     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       exp_out1,
    output logic       exp_out2,
    output logic       valid,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        OFFER = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] IDX_LAST  = 3'(NUM_VEC - 1);

    seqState_t  r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_idx;
    logic [2:0] r_vec;
    logic       r_exp1;
    logic       r_exp2;

    seqState_t  w_nextState;
    logic [7:0] w_nextCnt;
    logic [2:0] w_nextIdx;
    logic       w_loadVec;
    logic [2:0] w_vec;

    // Maps the index of the vector about to be loaded onto the driven bits.
`ifdef ABC_SEQ_GRAY_EN
    assign w_vec = w_nextIdx ^ (w_nextIdx >> 1);
`else
    assign w_vec = w_nextIdx;
`endif

    // Next-state logic: also decides when the counter, index and vector
    // registers reload, so the vector bits can only change on a start in
    // IDLE or on an accepted transfer.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_loadVec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = HOLD;
                    w_nextIdx   = 3'd0;
                    w_nextCnt   = 8'd0;
                    w_loadVec   = 1'b1;
                end
            end
            HOLD: begin
                w_nextCnt = r_cnt + 8'd1;
                if (r_cnt == HOLD_LAST) begin
                    w_nextState = OFFER;
                end
            end
            OFFER: begin
                if (ready) begin
                    if (r_idx == IDX_LAST) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = HOLD;
                        w_nextIdx   = r_idx + 3'd1;
                        w_nextCnt   = 8'd0;
                        w_loadVec   = 1'b1;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, counter and index registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
        end
    end

    // Vector bits and their expected AND results load together so they
    // always describe the same vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec  <= 3'd0;
            r_exp1 <= 1'b0;
            r_exp2 <= 1'b0;
        end else if (w_loadVec) begin
            r_vec  <= w_vec;
            r_exp1 <= w_vec[2] & w_vec[1];
            r_exp2 <= w_vec[2] & w_vec[0];
        end
    end

    assign a        = r_vec[2];
    assign b        = r_vec[1];
    assign c        = r_vec[0];
    assign exp_out1 = r_exp1;
    assign exp_out2 = r_exp2;
    assign vec_idx  = r_idx;
    assign valid    = (r_state == OFFER);
    assign busy     = (r_state == HOLD) || (r_state == OFFER);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_abc_vector_sequencer.sv
// Self-checking bench for abc_vector_sequencer: a full default run checked
// cycle by cycle against a table of expected vectors, then hand-written
// sequences for backpressure, mid-run reset, ignored start pulses and the
// minimal HOLD_CYCLES=1 / NUM_VEC=1 configuration.
module tb_abc_vector_sequencer;

    typedef struct {
        logic [2:0] idx;
        logic [2:0] abc;
        logic       exp1;
        logic       exp2;
    } vecRecord_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic a, b, c, expOut1, expOut2, valid, busy, done;
    logic [2:0] vecIdx;

    logic start2 = 1'b0;
    logic a2, b2, c2, expOut1b, expOut2b, valid2, busy2, done2;
    logic [2:0] vecIdx2;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    vecRecord_t vecTable [8];

    always #5 clk = ~clk;

    abc_vector_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .a(a), .b(b), .c(c), .exp_out1(expOut1), .exp_out2(expOut2),
        .valid(valid), .vec_idx(vecIdx), .busy(busy), .done(done)
    );

    abc_vector_sequencer #(.HOLD_CYCLES(1), .NUM_VEC(1)) dutMin (
        .clk(clk), .rst(rst), .start(start2), .ready(1'b1),
        .a(a2), .b(b2), .c(c2), .exp_out1(expOut1b), .exp_out2(expOut2b),
        .valid(valid2), .vec_idx(vecIdx2), .busy(busy2), .done(done2)
    );

    // Counts done pulses of the main instance, sampled away from the edge.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic rs);
        start = s;
        ready = r;
        rst   = rs;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input string name, input int i);
        checkOutput({name, " abc"}, {5'd0, a, b, c}, {5'd0, vecTable[i].abc});
        checkOutput({name, " idx"}, {5'd0, vecIdx}, {5'd0, vecTable[i].idx});
        checkOutput({name, " exp"}, {6'd0, expOut1, expOut2},
                    {6'd0, vecTable[i].exp1, vecTable[i].exp2});
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, " valid timeout"}, {7'd0, valid}, 8'd1);
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, " done timeout"}, {7'd0, done}, 8'd1);
    endtask

    initial begin
        logic [2:0] prevAbc;
        int doneBefore;

`ifdef ABC_SEQ_GRAY_EN
        vecTable[0] = '{3'd0, 3'b000, 1'b0, 1'b0};
        vecTable[1] = '{3'd1, 3'b001, 1'b0, 1'b0};
        vecTable[2] = '{3'd2, 3'b011, 1'b0, 1'b0};
        vecTable[3] = '{3'd3, 3'b010, 1'b0, 1'b0};
        vecTable[4] = '{3'd4, 3'b110, 1'b1, 1'b0};
        vecTable[5] = '{3'd5, 3'b111, 1'b1, 1'b1};
        vecTable[6] = '{3'd6, 3'b101, 1'b0, 1'b1};
        vecTable[7] = '{3'd7, 3'b100, 1'b0, 1'b0};
`else
        vecTable[0] = '{3'd0, 3'b000, 1'b0, 1'b0};
        vecTable[1] = '{3'd1, 3'b001, 1'b0, 1'b0};
        vecTable[2] = '{3'd2, 3'b010, 1'b0, 1'b0};
        vecTable[3] = '{3'd3, 3'b011, 1'b0, 1'b0};
        vecTable[4] = '{3'd4, 3'b100, 1'b0, 1'b0};
        vecTable[5] = '{3'd5, 3'b101, 1'b0, 1'b1};
        vecTable[6] = '{3'd6, 3'b110, 1'b1, 1'b0};
        vecTable[7] = '{3'd7, 3'b111, 1'b1, 1'b1};
`endif

        // Reset values.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("reset outputs",
                    {a, b, c, expOut1, expOut2, valid, busy, done}, 8'd0);
        checkOutput("reset idx", {5'd0, vecIdx}, 8'd0);

        // Full default run with ready high: 5 hold cycles then 1 offer cycle.
        applyStimulus(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        prevAbc = 3'b000;
        for (int i = 0; i < 8; i++) begin
            for (int h = 0; h < 5; h++) begin
                checkOutput($sformatf("run v%0d h%0d valid", i, h), {7'd0, valid}, 8'd0);
                checkOutput($sformatf("run v%0d h%0d busy", i, h), {7'd0, busy}, 8'd1);
                checkVector($sformatf("run v%0d h%0d", i, h), i);
                tick();
            end
            checkOutput($sformatf("run v%0d offer valid", i), {7'd0, valid}, 8'd1);
            checkVector($sformatf("run v%0d offer", i), i);
`ifdef ABC_SEQ_GRAY_EN
            if (i > 0)
                checkOutput($sformatf("gray dist v%0d", i),
                            8'($countones(prevAbc ^ {a, b, c})), 8'd1);
`endif
            prevAbc = {a, b, c};
            tick();
        end
        checkOutput("run done pulse", {5'd0, done, busy, valid}, 8'b100);
        checkVector("run done hold", 7);
        tick();
        checkOutput("run idle", {5'd0, done, busy, valid}, 8'b000);
        checkVector("run idle hold", 7);
        checkOutput("run done count", 8'(doneCount), 8'd1);

        // Backpressure at vector 3: ready low for 10 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitValid($sformatf("bp v%0d", i), 20);
            applyStimulus(1'b0, 1'b1, 1'b0);
            ready = 1'b0;
        end
        waitValid("bp v3", 20);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("bp stall%0d valid", k), {7'd0, valid}, 8'd1);
            checkVector($sformatf("bp stall%0d", k), 3);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("bp advance valid", {7'd0, valid}, 8'd0);
        checkVector("bp advance", 4);
        waitDone("bp", 60);
        tick();
        checkOutput("bp done count", 8'(doneCount), 8'd2);

        // Reset in the middle of HOLD at vector 5: no done pulse, clean restart.
        applyStimulus(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        begin
            int n = 0;
            while (vecIdx !== 3'd5 && n < 60) begin
                tick();
                n++;
            end
        end
        checkVector("rst reached v5", 5);
        tick();
        tick();
        checkOutput("rst in hold", {6'd0, busy, valid}, 8'b10);
        doneBefore = doneCount;
        applyStimulus(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        checkOutput("rst outputs",
                    {a, b, c, expOut1, expOut2, valid, busy, done}, 8'd0);
        checkOutput("rst idx", {5'd0, vecIdx}, 8'd0);
        for (int k = 0; k < 8; k++) tick();
        checkOutput("rst no done", 8'(doneCount - doneBefore), 8'd0);
        checkOutput("rst stays idle", {7'd0, busy}, 8'd0);

        // Restart after reset, with start pulses in HOLD and DONE ignored.
        applyStimulus(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        checkVector("restart v0", 0);
        checkOutput("restart busy", {7'd0, busy}, 8'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        checkVector("start in hold ignored", 0);
        waitDone("ignore", 60);
        applyStimulus(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        checkOutput("start in done idle", {6'd0, busy, done}, 8'd0);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("start in done no run", {7'd0, busy}, 8'd0);
        checkOutput("single run done count", 8'(doneCount - doneBefore), 8'd1);
        checkVector("after run hold", 7);

        // Minimal configuration: HOLD_CYCLES=1, NUM_VEC=1, ready tied high.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("min E+1", {4'd0, busy2, valid2, done2, vecIdx2 == 3'd0}, 8'b1001);
        checkOutput("min E+1 abc", {3'd0, a2, b2, c2, expOut1b, expOut2b}, 8'd0);
        tick();
        checkOutput("min E+2 valid", {5'd0, busy2, valid2, done2}, 8'b110);
        tick();
        checkOutput("min done", {5'd0, busy2, valid2, done2}, 8'b001);
        tick();
        checkOutput("min idle", {5'd0, busy2, valid2, done2}, 8'b000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
